// File: rtl/imuldiv_div_resp_fmt_pkg.sv
// Shared constants and helpers for the divider response formatter.
// The 64-bit divider response is {rem[63:32], quo[31:0]}; tag records are {sel_rem, dst}.
package imuldiv_div_resp_fmt_pkg;

    localparam int unsigned RESULT_W  = 64;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned REM_MSB   = 63;
    localparam int unsigned REM_LSB   = 32;
    localparam int unsigned QUO_MSB   = 31;
    localparam int unsigned QUO_LSB   = 0;
    localparam int unsigned TAG_W_DEF = 5;

    typedef struct packed {
        logic                 sel_rem;
        logic [TAG_W_DEF-1:0] dst;
    } tag_rec_t;

    function automatic tag_rec_t pack_tag(input logic sel_rem, input logic [TAG_W_DEF-1:0] dst);
        tag_rec_t t;
        t.sel_rem = sel_rem;
        t.dst     = dst;
        return t;
    endfunction

    function automatic logic [TAG_W_DEF-1:0] unpack_dst(input tag_rec_t t);
        return t.dst;
    endfunction

    // Select remainder or quotient half of a divider response.
    function automatic logic [WORD_W-1:0] sel_word(input logic [RESULT_W-1:0] r,
                                                   input logic                sel_rem);
        return sel_rem ? r[REM_MSB:REM_LSB] : r[QUO_MSB:QUO_LSB];
    endfunction

endpackage

// File: rtl/imuldiv_div_resp_fmt_if.sv
// Tag-push, divider-response and writeback channels of the divider response formatter.
interface imuldiv_div_resp_fmt_if
    import imuldiv_div_resp_fmt_pkg::*;
#(
    parameter int unsigned TAG_W = TAG_W_DEF
);
    logic                tag_val;
    logic                tag_rdy;
    logic                tag_sel_rem;
    logic [TAG_W-1:0]    tag_dst;
    logic [RESULT_W-1:0] divresp_msg_result;
    logic                divresp_val;
    logic                divresp_rdy;
    logic [WORD_W-1:0]   wb_msg_data;
    logic [TAG_W-1:0]    wb_msg_dst;
    logic                wb_val;
    logic                wb_rdy;

    modport master (
        output tag_val, tag_sel_rem, tag_dst, divresp_msg_result, divresp_val, wb_rdy,
        input  tag_rdy, divresp_rdy, wb_msg_data, wb_msg_dst, wb_val
    );

    modport slave (
        input  tag_val, tag_sel_rem, tag_dst, divresp_msg_result, divresp_val, wb_rdy,
        output tag_rdy, divresp_rdy, wb_msg_data, wb_msg_dst, wb_val
    );
endinterface

// File: rtl/imuldiv_tag_fifo.sv
// In-order DEPTH x W tag FIFO; DEPTH must be a power of two so pointers wrap naturally.
// A push is accepted while full only when a pop happens in the same cycle.
module imuldiv_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign rdata_o = mem_q[head_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_push) tail_d = tail_q + PTR_W'(1);
        if (do_pop)  head_d = head_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (do_push) mem_q[tail_q] <= wdata_i;
        end
    end
endmodule

// File: rtl/imuldiv_div_resp_fmt.sv
// Divider response formatter: pairs each in-order divider response with a queued tag and
// emits the selected word. IMULDIV_DIV_RESP_BYPASS_EN selects a combinational 0-cycle path.
module imuldiv_div_resp_fmt
    import imuldiv_div_resp_fmt_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = TAG_W_DEF
) (
    input logic                   clk,
    input logic                   rst_n,
    imuldiv_div_resp_fmt_if.slave bus
);
    localparam int unsigned TREC_W = 1 + TAG_W;

    logic [TREC_W-1:0] head_tag;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              resp_rdy;
    logic [WORD_W-1:0] sel_data;

    imuldiv_tag_fifo #(
        .DEPTH (DEPTH),
        .W     (TREC_W)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.tag_val),
        .pop_i   (pop),
        .wdata_i ({bus.tag_sel_rem, bus.tag_dst}),
        .rdata_o (head_tag),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign sel_data         = sel_word(bus.divresp_msg_result, head_tag[TAG_W]);
    assign bus.tag_rdy      = !fifo_full;
    assign bus.divresp_rdy  = resp_rdy;
    assign pop              = bus.divresp_val && resp_rdy;

`ifdef IMULDIV_DIV_RESP_BYPASS_EN
    // Response passes straight through; the tag retires when the writeback fires.
    assign resp_rdy        = !fifo_empty && bus.wb_rdy;
    assign bus.wb_val      = bus.divresp_val && !fifo_empty;
    assign bus.wb_msg_data = sel_data;
    assign bus.wb_msg_dst  = head_tag[TAG_W-1:0];
`else
    logic              wb_val_q, wb_val_d;
    logic [WORD_W-1:0] wb_data_q, wb_data_d;
    logic [TAG_W-1:0]  wb_dst_q, wb_dst_d;

    assign resp_rdy        = !fifo_empty && (!wb_val_q || bus.wb_rdy);
    assign bus.wb_val      = wb_val_q;
    assign bus.wb_msg_data = wb_data_q;
    assign bus.wb_msg_dst  = wb_dst_q;

    // Reload takes priority over drain so back-to-back responses stream at one per cycle.
    always_comb begin
        wb_val_d  = wb_val_q;
        wb_data_d = wb_data_q;
        wb_dst_d  = wb_dst_q;
        if (pop) begin
            wb_val_d  = 1'b1;
            wb_data_d = sel_data;
            wb_dst_d  = head_tag[TAG_W-1:0];
        end else if (wb_val_q && bus.wb_rdy) begin
            wb_val_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_val_q  <= 1'b0;
            wb_data_q <= '0;
            wb_dst_q  <= '0;
        end else begin
            wb_val_q  <= wb_val_d;
            wb_data_q <= wb_data_d;
            wb_dst_q  <= wb_dst_d;
        end
    end
`endif
endmodule

// File: tb/tb_imuldiv_div_resp_fmt.sv
// Self-checking bench for imuldiv_div_resp_fmt: directed scenarios then random traffic,
// compared cycle by cycle against a queue-based transaction model.
module tb_imuldiv_div_resp_fmt;
    import imuldiv_div_resp_fmt_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 5;

    typedef struct {
        logic             sel;
        logic [TAG_W-1:0] dst;
    } mtag_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imuldiv_div_resp_fmt_if #(.TAG_W(TAG_W)) bus_if ();

    imuldiv_div_resp_fmt #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    mtag_t       q[$];
    bit          m_wb_val;
    logic [31:0] m_data;
    logic [TAG_W-1:0] m_dst;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [63:0] r, input logic sel);
        return sel ? 32'(r >> 32) : 32'(r);
    endfunction

    task automatic drive(input logic tv, input logic sel, input logic [TAG_W-1:0] dst,
                         input logic dv, input logic [63:0] res, input logic wr);
        bus_if.tag_val            = tv;
        bus_if.tag_sel_rem        = sel;
        bus_if.tag_dst            = dst;
        bus_if.divresp_val        = dv;
        bus_if.divresp_msg_result = res;
        bus_if.wb_rdy             = wr;
    endtask

    task automatic model_reset();
        q.delete();
        m_wb_val = 1'b0;
        m_data   = '0;
        m_dst    = '0;
    endtask

    // Check outputs against the model for the current inputs, then advance one clock.
    task automatic step(input string tag);
        bit          has;
        bit          exp_trdy, exp_drdy, exp_wbval, resp_fire, push_ok;
        logic [31:0] exp_data;
        logic [TAG_W-1:0] exp_dst;
        mtag_t       t;
        #1;
        has      = (q.size() != 0);
        exp_trdy = (q.size() != DEPTH);
`ifdef IMULDIV_DIV_RESP_BYPASS_EN
        exp_drdy  = has && bus_if.wb_rdy;
        exp_wbval = bus_if.divresp_val && has;
        exp_data  = has ? pick(bus_if.divresp_msg_result, q[0].sel) : 32'h0;
        exp_dst   = has ? q[0].dst : '0;
`else
        exp_drdy  = has && (!m_wb_val || bus_if.wb_rdy);
        exp_wbval = m_wb_val;
        exp_data  = m_data;
        exp_dst   = m_dst;
`endif
        chk({tag, ".tag_rdy"}, 64'(bus_if.tag_rdy), 64'(exp_trdy));
        chk({tag, ".divresp_rdy"}, 64'(bus_if.divresp_rdy), 64'(exp_drdy));
        chk({tag, ".wb_val"}, 64'(bus_if.wb_val), 64'(exp_wbval));
        if (exp_wbval) begin
            chk({tag, ".wb_data"}, 64'(bus_if.wb_msg_data), 64'(exp_data));
            chk({tag, ".wb_dst"}, 64'(bus_if.wb_msg_dst), 64'(exp_dst));
        end
        @(posedge clk);
        resp_fire = bus_if.divresp_val && exp_drdy;
        push_ok   = bus_if.tag_val && ((q.size() < DEPTH) || resp_fire);
        if (resp_fire) begin
            t = q.pop_front();
`ifndef IMULDIV_DIV_RESP_BYPASS_EN
            m_wb_val = 1'b1;
            m_data   = pick(bus_if.divresp_msg_result, t.sel);
            m_dst    = t.dst;
`endif
        end else if (m_wb_val && bus_if.wb_rdy) begin
            m_wb_val = 1'b0;
        end
        if (push_ok) q.push_back('{sel: bus_if.tag_sel_rem, dst: bus_if.tag_dst});
        @(negedge clk);
    endtask

    initial begin
        drive(0, 0, '0, 0, '0, 1);
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset.wb_val", 64'(bus_if.wb_val), 64'(0));
        chk("reset.wb_data", 64'(bus_if.wb_msg_data), 64'(0));
        chk("reset.wb_dst", 64'(bus_if.wb_msg_dst), 64'(0));
        chk("reset.tag_rdy", 64'(bus_if.tag_rdy), 64'(1));
        chk("reset.divresp_rdy", 64'(bus_if.divresp_rdy), 64'(0));
        rst_n = 1'b1;

        // Response with no tag queued must stall.
        drive(0, 0, '0, 1, 64'h0000_1234_0000_5678, 1);
        repeat (3) step("t1");
        chk("t1.no_wb", 64'(bus_if.wb_val), 64'(0));

        // Quotient select.
        drive(1, 0, 5'd3, 0, '0, 1);
        step("t2_push");
        drive(0, 0, '0, 1, 64'h0000_0000_0000_000d, 1);
`ifdef IMULDIV_DIV_RESP_BYPASS_EN
        #1;
        chk("t2.wb_val", 64'(bus_if.wb_val), 64'(1));
        chk("t2.wb_data", 64'(bus_if.wb_msg_data), 64'h0000_000d);
        chk("t2.wb_dst", 64'(bus_if.wb_msg_dst), 64'(3));
        step("t2_resp");
`else
        step("t2_resp");
        chk("t2.wb_val", 64'(bus_if.wb_val), 64'(1));
        chk("t2.wb_data", 64'(bus_if.wb_msg_data), 64'h0000_000d);
        chk("t2.wb_dst", 64'(bus_if.wb_msg_dst), 64'(3));
`endif
        drive(0, 0, '0, 0, '0, 1);
        step("t2_idle");

        // Remainder select.
        drive(1, 1, 5'd5, 0, '0, 1);
        step("t3_push");
        drive(0, 0, '0, 1, 64'h0000_002e_0000_000a, 1);
`ifdef IMULDIV_DIV_RESP_BYPASS_EN
        #1;
        chk("t3.wb_data", 64'(bus_if.wb_msg_data), 64'h0000_002e);
        chk("t3.wb_dst", 64'(bus_if.wb_msg_dst), 64'(5));
        step("t3_resp");
`else
        step("t3_resp");
        chk("t3.wb_data", 64'(bus_if.wb_msg_data), 64'h0000_002e);
        chk("t3.wb_dst", 64'(bus_if.wb_msg_dst), 64'(5));
`endif
        drive(0, 0, '0, 0, '0, 1);
        step("t3_idle");

        // Fill, overflow push, push+pop while full, drain across pointer wrap.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'(i), 5'(10 + i), 0, '0, 1);
            step("t4_fill");
        end
        chk("t4.full", 64'(bus_if.tag_rdy), 64'(0));
        drive(1, 0, 5'd14, 0, '0, 1);
        step("t4_overflow");
        drive(1, 1, 5'd15, 1, 64'hAAAA_0001_BBBB_0001, 1);
        step("t4_pushpop");
        chk("t4.still_full", 64'(bus_if.tag_rdy), 64'(0));
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, '0, 1, {32'(32'h100 + i), 32'(32'h200 + i)}, 1);
            step("t4_drain");
        end

        // Backpressure: first word held, second waits.
        drive(1, 0, 5'd20, 0, '0, 0);
        step("t5_push0");
        drive(1, 1, 5'd21, 0, '0, 0);
        step("t5_push1");
        drive(0, 0, '0, 1, 64'h1111_1111_2222_2222, 0);
        step("t5_resp0");
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, '0, 1, 64'h3333_3333_4444_4444 + 64'(i), 0);
            step("t5_hold");
        end
        chk("t5.divresp_rdy", 64'(bus_if.divresp_rdy), 64'(0));
`ifndef IMULDIV_DIV_RESP_BYPASS_EN
        chk("t5.held_data", 64'(bus_if.wb_msg_data), 64'h2222_2222);
`endif
        drive(0, 0, '0, 1, 64'h5555_5555_6666_6666, 1);
        repeat (3) step("t5_release");

        // Asynchronous reset with tags queued and a word pending.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 5'(24 + i), 0, '0, 0);
            step("t6_push");
        end
        drive(0, 0, '0, 1, 64'h7777_7777_8888_8888, 0);
        step("t6_resp");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.wb_val", 64'(bus_if.wb_val), 64'(0));
        chk("t6.wb_data", 64'(bus_if.wb_msg_data), 64'(0));
        chk("t6.wb_dst", 64'(bus_if.wb_msg_dst), 64'(0));
        chk("t6.tag_rdy", 64'(bus_if.tag_rdy), 64'(1));
        chk("t6.divresp_rdy", 64'(bus_if.divresp_rdy), 64'(0));
        model_reset();
        drive(0, 0, '0, 0, '0, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TAG_W'($urandom),
                  ($urandom_range(0, 9) < 6), {$urandom, $urandom},
                  ($urandom_range(0, 9) < 7));
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
